// File: rtl/spi_master.sv
// SPI master: sends one (MEM_WIDTH+2)-bit command frame MSB-first on MOSI.
// RD_DATA frames also turn the link around and capture a MEM_WIDTH-bit reply from MISO.
module spi_master #(
   parameter int MEM_WIDTH     = 8,
   parameter int RD_TURNAROUND = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_control,
   input  logic [MEM_WIDTH-1:0] cmd_payload,
   output logic                 SS_n,
   output logic                 MOSI,
   input  logic                 MISO,
   output logic                 rd_valid,
   output logic [MEM_WIDTH-1:0] rd_data,
   output logic                 busy,
   output logic [2:0]           dbg_state
);

   localparam int FW     = MEM_WIDTH + 2;
   localparam int CW_RAW = $clog2(FW + RD_TURNAROUND + 1);
   localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;

   localparam logic [1:0] RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD   = 3'd1,
      SHIFT = 3'd2,
      WAIT  = 3'd3,
      RECV  = 3'd4,
      GAP   = 3'd5
   } state_e;

   state_e                 state_q;
   logic [FW-1:0]          shreg_q;
   logic [CW-1:0]          cnt_q;
   logic                   is_rd_q;
   logic                   ss_n_q;
   logic                   mosi_q;
   logic                   rd_valid_q;
   logic [MEM_WIDTH-2:0]   rx_q;
   logic [MEM_WIDTH-1:0]   rx_d;
   logic [MEM_WIDTH-1:0]   rd_data_q;

   // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
   // cmd_ready is high only in IDLE outside reset, and the requester must hold
   // cmd_valid and its fields stable until that edge.
   assign cmd_ready = (state_q == IDLE) && !rst;
   assign busy      = !cmd_ready;
   assign SS_n      = ss_n_q;
   assign MOSI      = mosi_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign dbg_state = state_q;

   // Reply byte including the bit arriving on the current edge.
   assign rx_d = {rx_q, MISO};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         cnt_q      <= '0;
         is_rd_q    <= 1'b0;
         ss_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rx_q       <= '0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               ss_n_q <= 1'b1;
               mosi_q <= 1'b0;
               if (cmd_valid && cmd_ready) begin
                  shreg_q <= {cmd_control, cmd_payload};
                  is_rd_q <= (cmd_control == RD_DATA);
                  ss_n_q  <= 1'b0;
                  mosi_q  <= cmd_control[1];
                  state_q <= CMD;
               end
            end
            CMD: begin
               mosi_q  <= shreg_q[FW-1];
               shreg_q <= {shreg_q[FW-2:0], 1'b0};
               cnt_q   <= CW'(FW - 1);
               state_q <= SHIFT;
            end
            SHIFT: begin
               if (cnt_q == '0) begin
                  mosi_q <= 1'b0;
                  if (is_rd_q) begin
                     cnt_q   <= CW'(RD_TURNAROUND - 1);
                     state_q <= WAIT;
                  end else begin
                     ss_n_q  <= 1'b1;
                     state_q <= GAP;
                  end
               end else begin
                  mosi_q  <= shreg_q[FW-1];
                  shreg_q <= {shreg_q[FW-2:0], 1'b0};
                  cnt_q   <= cnt_q - 1'b1;
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  cnt_q   <= CW'(MEM_WIDTH - 1);
                  state_q <= RECV;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RECV: begin
               rx_q <= rx_d[MEM_WIDTH-2:0];
               if (cnt_q == '0) begin
                  rd_data_q  <= rx_d;
                  rd_valid_q <= 1'b1;
                  ss_n_q     <= 1'b1;
                  state_q    <= GAP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            GAP: begin
               ss_n_q  <= 1'b1;
               mosi_q  <= 1'b0;
               is_rd_q <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               ss_n_q  <= 1'b1;
               mosi_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: driver pushes expected frames/replies, a monitor
// pops and compares them as SS_n frames close and rd_valid pulses appear.
module tb_spi_master;

   localparam int MW = 8;
   localparam int T  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic [1:0]    cmd_control = 2'b00;
   logic [MW-1:0] cmd_payload = '0;
   logic          MISO = 1'b1;
   logic          cmd_ready, SS_n, MOSI, rd_valid, busy;
   logic [MW-1:0] rd_data;
   logic [2:0]    dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   spi_master #(.MEM_WIDTH(MW), .RD_TURNAROUND(T)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_control(cmd_control), .cmd_payload(cmd_payload), .SS_n(SS_n),
      .MOSI(MOSI), .MISO(MISO), .rd_valid(rd_valid), .rd_data(rd_data),
      .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard queues
   logic [10:0]   exp_q[$];
   int            exp_len_q[$];
   logic [MW-1:0] exp_rd_q[$];
   int            exp_rd_cyc_q[$];

   // MISO: reply byte MSB-first in its window, 1s elsewhere
   int            miso_start = -100;
   logic [MW-1:0] miso_byte = '0;
   always @(negedge clk) begin
      if (cyc >= miso_start && cyc < miso_start + MW) MISO = miso_byte[MW-1-(cyc-miso_start)];
      else MISO = 1'b1;
   end

   // monitor
   logic [10:0] cap = '0;
   int          flen = 0;
   bit          in_frame = 0;
   bit          tail_mosi = 0;
   always @(negedge clk) begin
      if (SS_n === 1'b0) begin
         if (!in_frame) begin
            in_frame = 1; cap = '0; flen = 0; tail_mosi = 0;
         end
         if (flen < 11) cap = {cap[9:0], MOSI};
         else if (MOSI !== 1'b0) tail_mosi = 1;
         flen++;
      end else if (in_frame) begin
         in_frame = 0;
         check("frame_expected", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            check("frame_bits", cap, exp_q.pop_front());
            check("frame_len", flen, exp_len_q.pop_front());
            check("frame_tail_mosi", tail_mosi, 0);
         end
      end
      if (rd_valid === 1'b1) begin
         check("rd_valid_expected", (exp_rd_q.size() > 0), 1);
         if (exp_rd_q.size() > 0) begin
            check("rd_data", rd_data, exp_rd_q.pop_front());
            check("rd_valid_cycle", cyc, exp_rd_cyc_q.pop_front());
            check("ss_n_at_rd_valid", SS_n, 1);
         end
      end
   end

   typedef struct {
      logic [1:0]    ctrl;
      logic [MW-1:0] pay;
      logic [10:0]   bits;
      int            len;
      bit            rd_en;
      logic [MW-1:0] exp_rd;
      logic [MW-1:0] miso;
      int            period;
      int            abort_at;
      int            hold;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs[NV];
   int   prev_k = -1000;

   task automatic send(input int vi, output int k);
      int waited;
      waited = 0;
      k = -1;
      @(negedge clk);
      cmd_valid   = 1'b1;
      cmd_control = vecs[vi].ctrl;
      cmd_payload = vecs[vi].pay;
      while (k < 0 && waited < 100) begin
         if (cmd_ready === 1'b1) k = cyc;
         else begin
            @(negedge clk);
            waited++;
         end
      end
      check("cmd_accepted", (k >= 0), 1);
      if (k >= 0) begin
         if (vecs[vi].period > 0) check("accept_period", k - prev_k, vecs[vi].period);
         if (vecs[vi].hold >= 0) check("rd_data_hold", rd_data, vecs[vi].hold);
         prev_k = k;
         exp_q.push_back(vecs[vi].bits);
         exp_len_q.push_back(vecs[vi].len);
         if (vecs[vi].rd_en) begin
            exp_rd_q.push_back(vecs[vi].exp_rd);
            exp_rd_cyc_q.push_back(k + 20 + T);
         end
         if (vecs[vi].ctrl == 2'b11) begin
            miso_start = k + 12 + T;
            miso_byte  = vecs[vi].miso;
         end
         @(posedge clk);
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!(cmd_ready === 1'b1 && SS_n === 1'b1) && w < 100);
      check("returned_to_idle", cmd_ready, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int k;
      //           ctrl   pay    MOSI bits (CMD + frame)  len rd  exp_rd miso   per ab hold
      vecs[0] = '{2'b00, 8'hA5, 11'b0_00_10100101, 11, 1'b0, 8'h00, 8'h00, 0,  0, -1};
      vecs[1] = '{2'b01, 8'h3C, 11'b0_01_00111100, 11, 1'b0, 8'h00, 8'h00, 13, 0, -1};
      vecs[2] = '{2'b11, 8'h00, 11'b1_11_00000000, 21, 1'b1, 8'hAA, 8'hAA, 0,  0, -1};
      vecs[3] = '{2'b10, 8'h55, 11'b1_10_01010101, 11, 1'b0, 8'h00, 8'h00, 0,  0, -1};
      vecs[4] = '{2'b01, 8'hFF, 11'b0_01_11111111, 11, 1'b0, 8'h00, 8'h00, 13, 0, 'hAA};
      vecs[5] = '{2'b11, 8'h81, 11'b1_11_10000001, 21, 1'b1, 8'h3C, 8'h3C, 13, 0, -1};
      vecs[6] = '{2'b11, 8'h00, 11'b000_00111000,  6,  1'b0, 8'h00, 8'h00, 23, 6, -1};
      vecs[7] = '{2'b00, 8'h5A, 11'b0_00_01011010, 11, 1'b0, 8'h00, 8'h00, 0,  0, 0};
      vecs[8] = '{2'b11, 8'h42, 11'b1_11_01000010, 21, 1'b1, 8'h96, 8'h96, 13, 0, -1};

      // reset: held for three cycles, then idle
      repeat (3) begin
         @(negedge clk);
         check("ready_in_reset", cmd_ready, 0);
      end
      rst = 1'b0;
      #1;
      check("ready_first_cycle", cmd_ready, 1);
      check("busy_first_cycle", busy, 0);
      check("state_after_reset", dbg_state, 0);
      repeat (5) begin
         @(negedge clk);
         check("idle_ss_n", SS_n, 1);
         check("idle_mosi", MOSI, 0);
         check("idle_rd_valid", rd_valid, 0);
         check("idle_rd_data", rd_data, 0);
         check("idle_ready", cmd_ready, 1);
      end

      for (int vi = 0; vi < NV; vi++) begin
         send(vi, k);
         if (vi + 1 < NV && vecs[vi+1].period > 0) continue;
         @(negedge clk);
         cmd_valid = 1'b0;
         if (vecs[vi].abort_at > 0 && k >= 0) begin
            while (cyc < k + vecs[vi].abort_at) @(negedge clk);
            rst = 1'b1;
            #1;
            check("ready_during_rst", cmd_ready, 0);
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("abort_ss_n", SS_n, 1);
            check("abort_mosi", MOSI, 0);
            check("abort_rd_valid", rd_valid, 0);
            check("abort_rd_data", rd_data, 0);
            check("abort_ready", cmd_ready, 1);
            check("abort_state", dbg_state, 0);
         end
         wait_idle();
      end

      repeat (30) @(negedge clk);
      check("frames_pending", exp_q.size(), 0);
      check("reads_pending", exp_rd_q.size(), 0);
      check("final_rd_data", rd_data, 8'h96);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI master that drives the SPI-RAM slave from the opposite end of the link. It accepts one 10-bit command word (2-bit control plus MEM_WIDTH payload) through a valid/ready handshake and serialises it MSB-first on MOSI inside an SS_n-low frame. For RD_DATA commands it also holds SS_n low, samples the slave's MEM_WIDTH-bit reply on MISO, and returns the reply on a one-cycle rd_valid pulse. SCK is the system clock, so one MOSI/MISO bit moves per clk cycle.

## Interface
- MEM_WIDTH, 8, payload width. Frame word = MEM_WIDTH+2 bits.
- RD_TURNAROUND, 2, idle cycles between the last MOSI bit and the first MISO sample on RD_DATA (≥1).
- clk  in  1  system clock; all logic on its rising edge; also serves as SCK.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE and while rst is low.
- cmd_control  in  2  control_e: WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11.
- cmd_payload  in  MEM_WIDTH  address or data byte.
- SS_n  out  1  slave select, active low; SLAVE_NOT_SELECTED=1.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  MEM_WIDTH  last byte received; holds until the next RD_DATA completes.
- busy  out  1  equals !cmd_ready.

## Operation
- States: IDLE, CMD, SHIFT, WAIT, RECV, GAP.
- IDLE: SS_n=1, MOSI=0. When cmd_valid && cmd_ready, latch {cmd_control, cmd_payload} into a (MEM_WIDTH+2)-bit shift register and go to CMD. Later input changes are ignored.
- CMD (1 cycle): SS_n=0, MOSI=control[1]. This is the direction bit: 0 = write path, 1 = read path.
- SHIFT (MEM_WIDTH+2 cycles): SS_n=0. MOSI = frame bit MSB-first: control[1], control[0], payload[MEM_WIDTH-1..0]. A down-counter of ≥4 bits selects the bit. Exit goes to WAIT if control==RD_DATA, otherwise to GAP.
- WAIT (RD_TURNAROUND cycles): SS_n=0, MOSI=0, MISO ignored.
- RECV (MEM_WIDTH cycles): SS_n=0, MOSI=0. Shift in MISO MSB-first at each rising edge. Go to GAP.
- GAP (1 cycle): SS_n=1. If entered from RECV, load rd_data and pulse rd_valid in this cycle. Go to IDLE.
- MISO is sampled only in RECV.
- RD_ADDR and the write commands never produce rd_valid.
- rst high on any edge: next cycle is IDLE with SS_n=1, MOSI=0, rd_valid=0, rd_data=0, and all counters cleared. An in-flight frame is dropped with no rd_valid.

## Timing
- Reset values: SS_n=1, MOSI=0, rd_valid=0, rd_data=0, cmd_ready=0 while rst is high and 1 in the first cycle after.
- Let k be the cycle whose rising edge ends with cmd_valid && cmd_ready.
  - CMD is cycle k+1.
  - SHIFT is cycles k+2 .. k+11 (MEM_WIDTH=8).
- Write-type commands: GAP at k+12, IDLE at k+13. Minimum command period is 13 cycles.
- RD_DATA (T = RD_TURNAROUND):
  - WAIT is k+12 .. k+11+T.
  - RECV is k+12+T .. k+19+T.
  - GAP with rd_valid=1 is k+20+T.
  - IDLE is k+21+T. Minimum period is 21+T cycles.
- SS_n has at least one high cycle (GAP) between consecutive frames.
- cmd_valid asserted while not ready is neither accepted nor lost. The requester must hold it.

## Test plan
- Reset, then idle 5 cycles -> SS_n=1, MOSI=0, rd_valid=0, cmd_ready=1 from the first post-reset cycle.
- WR_ADDR, payload 8'hA5 -> SS_n low for cycles k+1..k+11. MOSI sequence is 0, 0,0, 1,0,1,0,0,1,0,1. SS_n high at k+12. No rd_valid.
- WR_DATA 8'h3C back-to-back with cmd_valid held high -> second acceptance exactly 13 cycles after the first. MOSI sequence is 0, 0,1, 0,0,1,1,1,1,0,0.
- RD_DATA 8'h00, T=2, MISO driving 8'b10101010 MSB-first over k+14..k+21 -> rd_valid=1 only at k+22 with rd_data=8'hAA. SS_n high at k+22.
- RD_ADDR 8'h55 -> MOSI sequence is 1, 1,0, 0,1,0,1,0,1,0,1. Goes to GAP at k+12 with no WAIT/RECV and no rd_valid.
- rst pulsed at k+6 of an RD_DATA frame -> SS_n=1 next cycle, no rd_valid ever, rd_data=0. Next command executes normally.
